inv_add_round_key: RTL
======================

INV_ADD_ROUND_KEY -- requirements
Module: inv_add_round_key

Interface
REQ-001 SHALL have parameter NUM_RK, default 11, number of stored round keys (AES-128).
REQ-002 SHALL have parameter PKT_W, default 132, packet width: [131:128] header, [127:0] state block.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and n_rst.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port key_wr_en  input  1  round-key write strobe.
REQ-007 SHALL have port key_wr_idx  input  4  round-key index written (0..NUM_RK-1).
REQ-008 SHALL have port key_in  input  128  round-key value.
REQ-009 SHALL have port key_clear  input  1  invalidate all stored keys.
REQ-010 SHALL have port in_valid  input  1  packet offered.
REQ-011 SHALL have port in_ready  output  1  packet accepted when in_valid and in_ready.
REQ-012 SHALL have port in_round  input  4  decryption round of offered packet (0..10).
REQ-013 SHALL have port data_in  input  132  offered packet.
REQ-014 SHALL have port out_valid  output  1  data_out holds a result.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have port data_out  output  132  result packet.
REQ-017 SHALL have port keys_ready  output  1  all NUM_RK keys loaded.
REQ-018 SHALL have port err  output  1  one-cycle pulse on dropped packet.

Function
REQ-019 SHALL run FSM states EMPTY, LOADING, ACTIVE; EMPTY->LOADING on first accepted key write; LOADING->ACTIVE the cycle after the written-mask becomes all ones; any state->EMPTY on key_clear.
REQ-020 SHALL accept key writes only in EMPTY/LOADING with key_wr_idx < NUM_RK; out-of-range index or write in ACTIVE ignored; rewrite of an index overwrites the value.
REQ-021 SHALL drive keys_ready = 1 only in ACTIVE.
REQ-022 SHALL drive in_ready = ACTIVE and not key_clear and (not out_valid or out_ready).
REQ-023 SHALL, on accepted packet with header != 0 and in_round <= 10, register data_out[127:0] = data_in[127:0] XOR key[10 - in_round], data_out[131:128] = header, out_valid = 1 next cycle (latency 1).
REQ-024 SHALL discard accepted packets with header == 0 (bubble): no output, no err.
REQ-025 SHALL discard accepted packets with header != 0 and in_round > 10, pulsing err for one cycle.
REQ-026 SHALL hold data_out and out_valid stable while out_valid and not out_ready.
REQ-027 SHALL clear out_valid when out_ready and no new result loads the same cycle; simultaneous drain and load yields back-to-back throughput of one packet per cycle.
REQ-028 SHALL, on key_clear, clear written-mask and out_valid in the next cycle; key_clear and key_wr_en same cycle: clear wins, write ignored.

Reset
REQ-029 SHALL on n_rst low immediately set state EMPTY, mask 0, out_valid 0, data_out 0, err 0, in_ready 0, keys_ready 0; key storage contents need not reset.
REQ-030 SHALL resume only via a full key reload after reset deassertion, including reset mid-load or mid-packet.

Structure
REQ-031 SHALL take PKT_W, HDR_W=4, BLK_W=128, NUM_RK and the FSM state enum from shared package aes_pkg.
REQ-032 SHALL implement key storage plus written-mask in sub-module round_key_buf (write port, one combinational read port, mask output).

Verification
REQ-033 SHALL cover: load keys k[i] = {16{8'(i)}} for i=0..10 -> keys_ready rises one cycle after idx 10 write.
REQ-034 SHALL cover: packet header 4'h5, block 128'h0, in_round 0 -> data_out = {4'h5, {16{8'h0A}}} one cycle later.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with result held -> in_ready 0, data_out unchanged; out_ready=1 with new in_valid -> back-to-back outputs.
REQ-036 SHALL cover: header 4'h0 -> no out_valid; header 4'h3 with in_round 11 -> err pulse, no out_valid.
REQ-037 SHALL cover: key_clear while out_valid=1 and in_valid=1 -> packet not accepted, out_valid 0, keys_ready 0 next cycle; n_rst pulse during LOADING -> state EMPTY, keys_ready 0 until full reload.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the inverse AddRoundKey stage.
// HDR_W/BLK_W describe the packet layout {header, state block}; NUM_RK is the
// AES-128 round-key count; rk_state_e tracks key-store readiness.
package aes_pkg;

  localparam int unsigned HDR_W    = 4;
  localparam int unsigned BLK_W    = 128;
  localparam int unsigned PKT_W    = HDR_W + BLK_W;
  localparam int unsigned NUM_RK   = 11;
  localparam int unsigned RK_IDX_W = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ACTIVE  = 2'd2
  } rk_state_e;

endpackage

// File: rtl/round_key_buf.sv
// Round-key storage with a per-entry written mask.
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset (clears the mask only)
//   i_wr_en        write strobe (already qualified by the caller)
//   i_wr_idx       entry written; indices >= NUM_RK are ignored
//   i_wr_data      key value written
//   i_clear        invalidate all entries; wins over a same-cycle write
//   i_rd_idx       combinational read index
//   o_rd_data      key at i_rd_idx (zero when out of range)
//   o_mask         one bit per entry, set once that entry has been written
module round_key_buf #(
  parameter int unsigned NUM_RK = aes_pkg::NUM_RK,
  parameter int unsigned IDX_W  = aes_pkg::RK_IDX_W
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_wr_en,
  input  logic [IDX_W-1:0]          i_wr_idx,
  input  logic [aes_pkg::BLK_W-1:0] i_wr_data,
  input  logic                      i_clear,
  input  logic [IDX_W-1:0]          i_rd_idx,
  output logic [aes_pkg::BLK_W-1:0] o_rd_data,
  output logic [NUM_RK-1:0]         o_mask
);
  import aes_pkg::*;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_RK - 1);

  logic [BLK_W-1:0]  r_keys [NUM_RK];
  logic [NUM_RK-1:0] r_mask;
  logic [NUM_RK-1:0] w_mask_d;
  logic              w_wr;

  assign w_wr = i_wr_en && !i_clear && (i_wr_idx <= LastIdx);

  always_comb begin
    w_mask_d = r_mask;
    if (i_clear) begin
      w_mask_d = '0;
    end else if (w_wr) begin
      w_mask_d[i_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mask <= '0;
    end else begin
      r_mask <= w_mask_d;
    end
  end

  // Key contents are only meaningful once the mask marks them, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_keys[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_idx <= LastIdx) ? r_keys[i_rd_idx] : '0;
  assign o_mask    = r_mask;

endmodule

// File: rtl/inv_add_round_key.sv
// Inverse AddRoundKey pipeline stage with its own round-key store.
// Keys are loaded first (EMPTY -> LOADING -> ACTIVE); packets are then
// XORed with key[NUM_RK-1 - in_round] and registered with one-cycle latency.
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   key_wr_en/key_wr_idx/key_in     round-key write port
//   key_clear                       drop all keys and any pending result
//   in_valid/in_ready/in_round/data_in   packet input handshake
//   out_valid/out_ready/data_out    result output handshake
//   keys_ready                      all keys loaded (ACTIVE)
//   err                             one-cycle pulse on a dropped packet
module inv_add_round_key #(
  parameter int unsigned NUM_RK = aes_pkg::NUM_RK,
  parameter int unsigned PKT_W  = aes_pkg::PKT_W
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      key_wr_en,
  input  logic [3:0]                key_wr_idx,
  input  logic [aes_pkg::BLK_W-1:0] key_in,
  input  logic                      key_clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_round,
  input  logic [PKT_W-1:0]          data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PKT_W-1:0]          data_out,
  output logic                      keys_ready,
  output logic                      err
);
  import aes_pkg::*;

  localparam logic [3:0] LastRk = 4'(NUM_RK - 1);

  rk_state_e         r_state;
  rk_state_e         w_state_d;
  logic              r_out_valid;
  logic [PKT_W-1:0]  r_data_out;
  logic              r_err;

  logic [NUM_RK-1:0] w_mask;
  logic [BLK_W-1:0]  w_rk;
  logic [HDR_W-1:0]  w_hdr;
  logic [BLK_W-1:0]  w_blk;
  logic [3:0]        w_rd_idx;
  logic              w_key_wr;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_hdr_nz;
  logic              w_round_ok;
  logic              w_load;
  logic              w_drop;

  // Keys are frozen once ACTIVE; only a clear (or reset) reopens loading.
  assign w_key_wr = key_wr_en && !key_clear && (r_state != ACTIVE) && (key_wr_idx <= LastRk);

  assign w_hdr      = data_in[PKT_W-1 -: HDR_W];
  assign w_blk      = data_in[BLK_W-1:0];
  assign w_hdr_nz   = |w_hdr;
  assign w_round_ok = in_round <= LastRk;
  // Decryption walks the key schedule backwards. Wraps for bad rounds, but
  // such packets are dropped and the buffer returns zero for them anyway.
  assign w_rd_idx   = LastRk - in_round;

  assign w_in_ready = (r_state == ACTIVE) && !key_clear && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_load     = w_accept && w_hdr_nz && w_round_ok;
  assign w_drop     = w_accept && w_hdr_nz && !w_round_ok;

  round_key_buf #(
    .NUM_RK (NUM_RK),
    .IDX_W  (4)
  ) u_round_key_buf (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_wr_en   (w_key_wr),
    .i_wr_idx  (key_wr_idx),
    .i_wr_data (key_in),
    .i_clear   (key_clear),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rk),
    .o_mask    (w_mask)
  );

  always_comb begin
    w_state_d = r_state;
    if (key_clear) begin
      w_state_d = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_key_wr) w_state_d = LOADING;
        // Mask is registered, so ACTIVE lands one cycle after it fills.
        LOADING: if (&w_mask) w_state_d = ACTIVE;
        ACTIVE:  w_state_d = ACTIVE;
        default: w_state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_drop;
      if (key_clear) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_load) begin
        r_data_out <= {w_hdr, w_blk ^ w_rk};
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign data_out   = r_data_out;
  assign keys_ready = (r_state == ACTIVE);
  assign err        = r_err;

endmodule
